// File: rtl/vga_mem_arb_if.sv
// Host write port and single-port frame-memory bus of vga_mem_arb.
// slave is the arbiter side; master is the host plus memory side.
interface vga_mem_arb_if #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 12
) ();
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arb.sv
// Arbitrates one single-port frame memory between VGA scan-out reads (absolute
// priority) and four-phase host writes, which fill the free half of each pixel slot.
module vga_mem_arb #(
  parameter int unsigned AW       = 19,
  parameter int unsigned DW       = 12,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [9:0]    hcnt,
  input  logic [9:0]    vcnt,
  vga_mem_arb_if.slave  bus,
  output logic [DW-1:0] pix_o
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_PEND = 2'd1;
  localparam logic [1:0] W_DONE = 2'd2;

  localparam logic [9:0] HLim      = 10'(H_ACTIVE);
  localparam logic [9:0] VLim      = 10'(V_ACTIVE);
  localparam logic [AW:0] FrameSize = (AW+1)'(H_ACTIVE * V_ACTIVE);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [DW-1:0] hdata_q, hdata_d;
  logic          err_q, err_d;
  logic          disp_q, disp_d;
  logic          blank_q, blank_d;
  logic [DW-1:0] pix_q, pix_d;

  logic          disp;
  logic          in_range;
  logic [AW-1:0] slot_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;

  assign disp      = pix_en && (hcnt < HLim) && (vcnt < VLim);
  assign in_range  = {1'b0, haddr_q} < FrameSize;
  // The origin slot reloads the counter, so no frame-size wrap logic is needed.
  assign slot_addr = ((hcnt == 10'd0) && (vcnt == 10'd0)) ? '0 : cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    haddr_d  = haddr_q;
    hdata_d  = hdata_q;
    err_d    = 1'b0;
    mem_addr = cnt_q;
    mem_we   = 1'b0;

    if (disp) begin
      mem_addr = slot_addr;
      cnt_d    = slot_addr + AW'(1);
    end

    case (state_q)
      W_IDLE: begin
        if (bus.wr_req) begin
          haddr_d = bus.wr_addr;
          hdata_d = bus.wr_data;
          state_d = W_PEND;
        end
      end
      W_PEND: begin
        if (!disp) begin
          mem_addr = haddr_q;
          mem_we   = in_range;
          err_d    = !in_range;
          state_d  = W_DONE;
        end
      end
      W_DONE: begin
        if (!bus.wr_req) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Read data returns one clk after the slot; pix_o captures it the clk after that.
  always_comb begin
    disp_d  = disp;
    blank_d = pix_en && !disp;
    pix_d   = pix_q;
    if (disp_q) begin
      pix_d = bus.mem_rdata;
    end else if (blank_q) begin
      pix_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
      haddr_q <= '0;
      hdata_q <= '0;
      err_q   <= 1'b0;
      disp_q  <= 1'b0;
      blank_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      haddr_q <= haddr_d;
      hdata_q <= hdata_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
      pix_q   <= pix_d;
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = hdata_q;
  assign bus.wr_ack    = (state_q == W_DONE);
  assign bus.wr_err    = err_q;
  assign pix_o         = pix_q;

endmodule

// File: tb/tb_vga_mem_arb.sv
// Self-checking bench for vga_mem_arb: directed scenarios plus a randomized raster
// with a random four-phase host, compared against a behavioural model.
module tb_vga_mem_arb;
  localparam int AW    = 19;
  localparam int DW    = 12;
  localparam int H     = 640;
  localparam int V     = 480;
  localparam int FRAME = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en;
  logic [9:0]    hcnt, vcnt;
  logic [DW-1:0] pix_o;

  vga_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  vga_mem_arb #(.AW(AW), .DW(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk   (clk),
    .rst   (rst),
    .pix_en(pix_en),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .bus   (bus),
    .pix_o (pix_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] pattern(input int unsigned a);
    logic [31:0] x;
    x = a * 32'd2654435761 + 32'h1234;
    return x[27:16];
  endfunction

  // Frame memory device: synchronous read, unwritten locations read a fixed pattern.
  logic [DW-1:0] mem_data [0:(1<<AW)-1];
  bit            written  [0:(1<<AW)-1];

  function automatic logic [DW-1:0] mem_rd(input int unsigned a);
    return written[a] ? mem_data[a] : pattern(a);
  endfunction

  always @(posedge clk) begin
    bus.mem_rdata <= mem_rd(int'(bus.mem_addr));
    if (bus.mem_we) begin
      mem_data[bus.mem_addr] <= bus.mem_wdata;
      written[bus.mem_addr]  <= 1'b1;
    end
  end

  // Behavioural model
  logic [DW-1:0] ref_mem [int unsigned];
  int            m_phase;  // 0 no write, 1 write waiting, 2 acknowledged
  logic [AW-1:0] m_haddr;
  logic [DW-1:0] m_hdata;
  int unsigned   m_next;
  logic [DW-1:0] m_pix;
  int            m_evt;    // 0 none, 1 visible pixel read, 2 blank pixel
  logic [DW-1:0] m_evt_val;
  logic          m_err;

  bit            l_rst, l_pe, l_req;
  int            l_h, l_v;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_data;

  logic          drv_req;
  logic [AW-1:0] drv_addr;
  logic [DW-1:0] drv_data;

  logic          e_we, e_ack, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_pix;

  function automatic logic [DW-1:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  function automatic bit is_disp(input bit pe, input int h, input int v);
    return pe && (h < H) && (v < V);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_haddr = '0; m_hdata = '0; m_next = 0;
    m_pix = '0; m_evt = 0; m_evt_val = '0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit d;
    int unsigned sa;
    if (l_rst) begin
      model_reset();
    end else begin
      d  = is_disp(l_pe, l_h, l_v);
      sa = l_v * H + l_h;
      if (m_evt == 1) m_pix = m_evt_val;
      else if (m_evt == 2) m_pix = '0;
      m_evt = d ? 1 : (l_pe ? 2 : 0);
      if (d) m_evt_val = ref_rd(sa);
      m_err = 1'b0;
      case (m_phase)
        0: if (l_req) begin m_haddr = l_addr; m_hdata = l_data; m_phase = 1; end
        1: if (!d) begin
          if (m_haddr < FRAME) ref_mem[m_haddr] = m_hdata;
          else m_err = 1'b1;
          m_phase = 2;
        end
        default: if (!l_req) m_phase = 0;
      endcase
      if (d) m_next = sa + 1;
    end
  endtask

  // One clk: drive at the falling edge, predictions valid 1 time unit later.
  task automatic cycle(input bit r, input bit pe, input int h, input int v);
    bit d;
    @(negedge clk);
    model_edge();
    rst = r; pix_en = pe; hcnt = 10'(h); vcnt = 10'(v);
    bus.wr_req = drv_req; bus.wr_addr = drv_addr; bus.wr_data = drv_data;
    l_rst = r; l_pe = pe; l_h = h; l_v = v;
    l_req = drv_req; l_addr = drv_addr; l_data = drv_data;
    if (r) model_reset();
    #1;
    d       = is_disp(pe, h, v);
    e_we    = !r && (m_phase == 1) && !d && (m_haddr < FRAME);
    e_addr  = d ? AW'(v * H + h) : ((m_phase == 1) ? m_haddr : AW'(m_next));
    e_wdata = m_hdata;
    e_ack   = (m_phase == 2);
    e_err   = m_err;
    e_pix   = m_pix;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 0, 0);
      n_checks += 5;
      if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", bus.wr_ack); end
      if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.wr_err); end
      if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.mem_we); end
      if (pix_o !== '0) begin n_fail++; $display("FAIL reset_pix got %h want 0", pix_o); end
      if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.mem_addr); end
    end
  endtask

  task automatic test_frame_start();
    for (int h = 0; h < 10; h++) begin
      cycle(1'b0, 1'b1, h, 0);
      n_checks += 2;
      if (bus.mem_addr !== AW'(h)) begin
        n_fail++; $display("FAIL fs_addr h=%0d got %0d want %0d", h, bus.mem_addr, h);
      end
      if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL fs_we h=%0d got %b want 0", h, bus.mem_we); end
      cycle(1'b0, 1'b0, h, 0);
      if (h >= 1) begin
        n_checks++;
        if (pix_o !== pattern(h - 1)) begin
          n_fail++; $display("FAIL fs_pix h=%0d got %h want %h", h - 1, pix_o, pattern(h - 1));
        end
      end
    end
  endtask

  task automatic test_collision();
    drv_req = 1'b1; drv_addr = AW'(1000); drv_data = 12'h3C5;
    cycle(1'b0, 1'b0, 9, 0);
    cycle(1'b0, 1'b1, 10, 0);
    n_checks += 2;
    if (bus.mem_addr !== AW'(10)) begin n_fail++; $display("FAIL col_disp_addr got %0d want 10", bus.mem_addr); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL col_disp_we got %b want 0", bus.mem_we); end
    drv_addr = AW'(2222); drv_data = 12'h000;
    cycle(1'b0, 1'b0, 10, 0);
    n_checks += 3;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL col_we got %b want 1", bus.mem_we); end
    if (bus.mem_addr !== AW'(1000)) begin n_fail++; $display("FAIL col_addr got %0d want 1000", bus.mem_addr); end
    if (bus.mem_wdata !== 12'h3C5) begin n_fail++; $display("FAIL col_wdata got %h want 3c5", bus.mem_wdata); end
    cycle(1'b0, 1'b0, 10, 0);
    n_checks += 2;
    if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL col_ack got %b want 1", bus.wr_ack); end
    if (pix_o !== pattern(10)) begin n_fail++; $display("FAIL col_pix got %h want %h", pix_o, pattern(10)); end
    drv_req = 1'b0;
    cycle(1'b0, 1'b0, 10, 0);
    n_checks++;
    if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL col_ack_hold got %b want 1", bus.wr_ack); end
    cycle(1'b0, 1'b0, 10, 0);
    n_checks++;
    if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL col_ack_drop got %b want 0", bus.wr_ack); end
  endtask

  task automatic test_blanking();
    cycle(1'b0, 1'b1, 700, 0);
    n_checks += 2;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL blank_we got %b want 0", bus.mem_we); end
    if (bus.mem_addr !== AW'(11)) begin n_fail++; $display("FAIL blank_addr got %0d want 11", bus.mem_addr); end
    cycle(1'b0, 1'b0, 700, 0);
    cycle(1'b0, 1'b0, 700, 0);
    n_checks++;
    if (pix_o !== '0) begin n_fail++; $display("FAIL blank_pix got %h want 0", pix_o); end
  endtask

  task automatic test_write_blank();
    int seen = 0;
    drv_req = 1'b1; drv_addr = AW'(5); drv_data = 12'h0F0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, (k % 2) == 0, 701 + k, 0);
      if (bus.mem_we === 1'b1) begin
        seen++;
        n_checks += 2;
        if (bus.mem_addr !== AW'(5)) begin n_fail++; $display("FAIL wb_addr got %0d want 5", bus.mem_addr); end
        if (bus.mem_wdata !== 12'h0F0) begin n_fail++; $display("FAIL wb_wdata got %h want 0f0", bus.mem_wdata); end
      end
    end
    n_checks++;
    if (seen !== 1) begin n_fail++; $display("FAIL wb_count got %0d writes want 1", seen); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, (k % 2) == 1, 704 + k, 0);
      n_checks++;
      if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL wb_ack k=%0d got %b want 1", k, bus.wr_ack); end
    end
    drv_req = 1'b0;
    cycle(1'b0, 1'b1, 707, 0);
    cycle(1'b0, 1'b0, 707, 0);
    n_checks++;
    if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL wb_ack_drop got %b want 0", bus.wr_ack); end
  endtask

  task automatic test_out_of_range();
    int we_cnt = 0;
    int err_cnt = 0;
    drv_req = 1'b1; drv_addr = AW'(FRAME); drv_data = 12'hFFF;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, (k % 2) == 0, 710 + k, 0);
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.wr_err === 1'b1) err_cnt++;
    end
    n_checks += 3;
    if (we_cnt !== 0) begin n_fail++; $display("FAIL oor_we got %0d writes want 0", we_cnt); end
    if (err_cnt !== 1) begin n_fail++; $display("FAIL oor_err got %0d pulses want 1", err_cnt); end
    if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL oor_ack got %b want 1", bus.wr_ack); end
    drv_req = 1'b0;
    cycle(1'b0, 1'b1, 715, 0);
    cycle(1'b0, 1'b0, 715, 0);
    n_checks++;
    if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL oor_ack_drop got %b want 0", bus.wr_ack); end
  endtask

  task automatic test_random();
    int hs = 0;
    int hmax, v;
    for (int f = 0; f < 2; f++) begin
      for (int li = 0; li < ((f == 0) ? 5 : 1); li++) begin
        v    = (li < 3) ? li : 477 + li;
        hmax = (f == 1) ? 21 : ((li < 3) ? 660 : 30);
        for (int h = 0; h < hmax; h++) begin
          for (int ph = 0; ph < 2; ph++) begin
            case (hs)
              0: if ($urandom_range(0, 3) == 0) begin
                drv_req  = 1'b1;
                drv_addr = ($urandom_range(0, 9) == 0) ? AW'(FRAME + $urandom_range(0, 1000))
                                                       : AW'($urandom_range(0, 3000));
                drv_data = DW'($urandom);
                hs = 1;
              end
              1: if (bus.wr_ack && ($urandom_range(0, 1) == 1)) begin
                drv_req = 1'b0; hs = 2;
              end else if ($urandom_range(0, 2) == 0) begin
                drv_addr = AW'($urandom); drv_data = DW'($urandom);
              end
              default: if (!bus.wr_ack) hs = 0;
            endcase
            cycle(1'b0, ph == 0, h, v);
            n_checks += 5;
            if (bus.mem_we !== e_we) begin
              n_fail++; $display("FAIL rnd_we h=%0d v=%0d got %b want %b", h, v, bus.mem_we, e_we);
            end
            if (bus.mem_addr !== e_addr) begin
              n_fail++; $display("FAIL rnd_addr h=%0d v=%0d got %0d want %0d", h, v, bus.mem_addr, e_addr);
            end
            if (e_we) begin
              n_checks++;
              if (bus.mem_wdata !== e_wdata) begin
                n_fail++; $display("FAIL rnd_wdata h=%0d v=%0d got %h want %h", h, v, bus.mem_wdata, e_wdata);
              end
            end
            if (bus.wr_ack !== e_ack) begin
              n_fail++; $display("FAIL rnd_ack h=%0d v=%0d got %b want %b", h, v, bus.wr_ack, e_ack);
            end
            if (bus.wr_err !== e_err) begin
              n_fail++; $display("FAIL rnd_err h=%0d v=%0d got %b want %b", h, v, bus.wr_err, e_err);
            end
            if (pix_o !== e_pix) begin
              n_fail++; $display("FAIL rnd_pix h=%0d v=%0d got %h want %h", h, v, pix_o, e_pix);
            end
          end
        end
      end
    end
    drv_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 20, 0);
      n_checks++;
      if (bus.wr_ack !== e_ack) begin n_fail++; $display("FAIL rnd_drain_ack got %b want %b", bus.wr_ack, e_ack); end
    end
    foreach (ref_mem[k]) begin
      n_checks++;
      if (mem_rd(k) !== ref_mem[k]) begin
        n_fail++; $display("FAIL rnd_mem addr=%0d got %h want %h", k, mem_rd(k), ref_mem[k]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    drv_req = 1'b1; drv_addr = AW'(3500); drv_data = 12'hABC;
    cycle(1'b0, 1'b0, 20, 0);
    cycle(1'b1, 1'b1, 21, 0);
    n_checks += 3;
    if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL rmw_ack got %b want 0", bus.wr_ack); end
    if (pix_o !== '0) begin n_fail++; $display("FAIL rmw_pix got %h want 0", pix_o); end
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_we got %b want 0", bus.mem_we); end
    drv_req = 1'b0;
    cycle(1'b1, 1'b0, 21, 0);
    n_checks++;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_we2 got %b want 0", bus.mem_we); end
    cycle(1'b0, 1'b0, 700, 0);
    cycle(1'b0, 1'b1, 701, 0);
    n_checks++;
    if (written[3500] !== 1'b0) begin n_fail++; $display("FAIL rmw_dropped got written=%b want 0", written[3500]); end
    drv_req = 1'b1; drv_addr = AW'(3501); drv_data = 12'h5A5;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, (k % 2) == 1, 702 + k, 0);
      if ((bus.mem_we === 1'b1) && (bus.mem_addr === AW'(3501)) && (bus.mem_wdata === 12'h5A5)) seen++;
    end
    n_checks += 2;
    if (seen !== 1) begin n_fail++; $display("FAIL rmw_rewrite got %0d writes want 1", seen); end
    if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL rmw_ack2 got %b want 1", bus.wr_ack); end
    drv_req = 1'b0;
    cycle(1'b0, 1'b0, 705, 0);
    cycle(1'b0, 1'b1, 706, 0);
    n_checks += 2;
    if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL rmw_ack_drop got %b want 0", bus.wr_ack); end
    if (mem_rd(3501) !== 12'h5A5) begin n_fail++; $display("FAIL rmw_mem got %h want 5a5", mem_rd(3501)); end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hcnt = '0; vcnt = '0;
    drv_req = 1'b0; drv_addr = '0; drv_data = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    l_rst = 1'b1; l_pe = 1'b0; l_req = 1'b0; l_h = 0; l_v = 0; l_addr = '0; l_data = '0;
    model_reset();
    test_reset();
    test_frame_start();
    test_collision();
    test_blanking();
    test_write_blank();
    test_out_of_range();
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
